// File: rtl/seg_display_reader.sv
// ---------------------------------------------------------------------------
// seg_display_reader
//
// Passive monitor for a four-digit, multiplexed seven-segment scan bus.
// It watches the active-low digit select and the active-low segment lines,
// waits until each {ctrlBits, dispcode} pair has been held steady, decodes
// the segment pattern back to a hex nibble, and publishes a full 16-bit word
// once every digit position has been seen. The block never drives the bus.
//
// Parameters
//   STABLE_CYCLES : consecutive rising edges a pair must be held before it
//                   is accepted (>= 2)
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous reset, active low
//   ctrlBits    in   [3:0] digit anode select, active low (1110 = digit 0)
//   dispcode    in   [7:0] segments, active low, {dp,g,f,e,d,c,b,a}
//   digits      out  [15:0] last complete frame {d3,d2,d1,d0}
//   dp          out  [3:0] decimal point per digit of last frame (1 = lit)
//   frame_valid out  one-cycle pulse when digits/dp update
//   changed     out  one-cycle pulse with frame_valid when digits changed
//   decode_err  out  sticky flag, an accepted pattern was not a hex glyph
// ---------------------------------------------------------------------------
module seg_display_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ctrlBits,
    input  logic [7:0]  dispcode,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        changed,
    output logic        decode_err
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);

    // Maps the seven active-low segment lines to {valid, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'h40:   result = {1'b1, 4'h0};
            7'h79:   result = {1'b1, 4'h1};
            7'h24:   result = {1'b1, 4'h2};
            7'h30:   result = {1'b1, 4'h3};
            7'h19:   result = {1'b1, 4'h4};
            7'h12:   result = {1'b1, 4'h5};
            7'h02:   result = {1'b1, 4'h6};
            7'h78:   result = {1'b1, 4'h7};
            7'h00:   result = {1'b1, 4'h8};
            7'h10:   result = {1'b1, 4'h9};
            7'h08:   result = {1'b1, 4'hA};
            7'h03:   result = {1'b1, 4'hB};
            7'h46:   result = {1'b1, 4'hC};
            7'h21:   result = {1'b1, 4'hD};
            7'h06:   result = {1'b1, 4'hE};
            7'h0E:   result = {1'b1, 4'hF};
            default: result = {1'b0, 4'h0};
        endcase
        return result;
    endfunction

    logic [3:0]        s_ctrl_q,     s_ctrl_d;
    logic [7:0]        s_code_q,     s_code_d;
    logic [STAB_W-1:0] stab_q,       stab_d;
    logic              acc_done_q,   acc_done_d;
    logic [3:0]        seen_q,       seen_d;
    logic [15:0]       shadow_q,     shadow_d;
    logic [3:0]        shadow_dp_q,  shadow_dp_d;
    logic [15:0]       digits_q,     digits_d;
    logic [3:0]        dp_q,         dp_d;
    logic              frame_valid_q, frame_valid_d;
    logic              changed_q,    changed_d;
    logic              decode_err_q, decode_err_d;

    logic              inputs_equal;
    logic [3:0]        slot_sel;
    logic              accept;
    logic [4:0]        decoded;
    logic [3:0]        seen_next;

    // Stability tracking: the sample registers follow the bus every edge and
    // the counter measures how long the bus has matched its own last sample.
    // acc_done stays set for the rest of a stable interval so one held pair
    // is accepted once only.
    always_comb begin
        s_ctrl_d     = ctrlBits;
        s_code_d     = dispcode;
        inputs_equal = (ctrlBits == s_ctrl_q) && (dispcode == s_code_q);

        stab_d = '0;
        if (inputs_equal) begin
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
        end

        // Only a select with exactly one low bit names a digit; blanking and
        // multi-digit selects are simply never accepted.
        case (ctrlBits)
            4'b1110: slot_sel = 4'b0001;
            4'b1101: slot_sel = 4'b0010;
            4'b1011: slot_sel = 4'b0100;
            4'b0111: slot_sel = 4'b1000;
            default: slot_sel = 4'b0000;
        endcase

        accept = inputs_equal && (slot_sel != 4'b0000) && !acc_done_q &&
                 (stab_d == STAB_ACC);

        acc_done_d = inputs_equal ? (acc_done_q | accept) : 1'b0;
    end

    // Frame assembly: an accepted digit lands in its shadow slot; the accept
    // that completes the set of four publishes the shadow (including the
    // digit accepted on this same edge) and starts a new collection.
    always_comb begin
        decoded       = decode_seg(dispcode[6:0]);
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        seen_d        = seen_q;
        seen_next     = seen_q | slot_sel;
        digits_d      = digits_q;
        dp_d          = dp_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;
        decode_err_d  = decode_err_q;

        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (slot_sel[i]) begin
                    shadow_d[i*4 +: 4] = decoded[3:0];
                    shadow_dp_d[i]     = ~dispcode[7];
                end
            end

            if (!decoded[4]) begin
                decode_err_d = 1'b1;
            end

            if (seen_next == 4'b1111) begin
                digits_d      = shadow_d;
                dp_d          = shadow_dp_d;
                frame_valid_d = 1'b1;
                changed_d     = (shadow_d != digits_q);
                seen_d        = 4'b0000;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    // State registers; reset discards any partially collected frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_ctrl_q      <= 4'hF;
            s_code_q      <= 8'hFF;
            stab_q        <= '0;
            acc_done_q    <= 1'b0;
            seen_q        <= 4'b0000;
            shadow_q      <= 16'h0000;
            shadow_dp_q   <= 4'h0;
            digits_q      <= 16'h0000;
            dp_q          <= 4'h0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            decode_err_q  <= 1'b0;
        end else begin
            s_ctrl_q      <= s_ctrl_d;
            s_code_q      <= s_code_d;
            stab_q        <= stab_d;
            acc_done_q    <= acc_done_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            decode_err_q  <= decode_err_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;
    assign decode_err  = decode_err_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// ---------------------------------------------------------------------------
// tb_seg_display_reader
//
// Directed bench for seg_display_reader with STABLE_CYCLES = 4. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge.
// A small monitor counts frame_valid pulses and remembers the last changed
// value seen with a pulse.
// ---------------------------------------------------------------------------
module tb_seg_display_reader;

    logic        CLK;
    logic        RST;
    logic [3:0]  ctrlBits;
    logic [7:0]  dispcode;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        changed;
    logic        decode_err;

    int checks;
    int errors;
    int fvCount;
    logic lastChanged;

    seg_display_reader #(.STABLE_CYCLES(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ctrlBits    (ctrlBits),
        .dispcode    (dispcode),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .changed     (changed),
        .decode_err  (decode_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Frame pulse monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (frame_valid) begin
            fvCount     <= fvCount + 1;
            lastChanged <= changed;
        end
    end

    task automatic driveDigit(input logic [3:0] ctrl, input logic [7:0] code, input int n);
        @(negedge CLK);
        ctrlBits = ctrl;
        dispcode = code;
        repeat (n) @(posedge CLK);
    endtask

    task automatic blankBus(input int n);
        driveDigit(4'b1111, 8'hFF, n);
        @(negedge CLK);
    endtask

    task automatic scan(input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3, input int n);
        driveDigit(4'b1110, c0, n);
        driveDigit(4'b1101, c1, n);
        driveDigit(4'b1011, c2, n);
        driveDigit(4'b0111, c3, n);
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST      = 1'b0;
        ctrlBits = 4'b1111;
        dispcode = 8'hFF;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL reset_digits got %h want %h", digits, 16'h0000); end
        checks++; if (dp !== 4'h0) begin errors++; $display("[TB] FAIL reset_dp got %h want %h", dp, 4'h0); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv got %b want 0", frame_valid); end
        checks++; if (changed !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed got %b want 0", changed); end
        checks++; if (decode_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", decode_err); end
    endtask

    task automatic test_basic();
        int startCount;
        startCount = fvCount;
        driveDigit(4'b1110, 8'hF9, 6);
        driveDigit(4'b1101, 8'hA4, 6);
        driveDigit(4'b1011, 8'hB0, 6);
        driveDigit(4'b0111, 8'h99, 3);
        @(negedge CLK);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_fv got %b want 0", frame_valid); end
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_fv_pulse got %b want 1", frame_valid); end
        checks++; if (changed !== 1'b1) begin errors++; $display("[TB] FAIL basic_changed got %b want 1", changed); end
        checks++; if (digits !== 16'h4321) begin errors++; $display("[TB] FAIL basic_digits got %h want %h", digits, 16'h4321); end
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_fv_fall got %b want 0", frame_valid); end
        @(posedge CLK);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL basic_frame_count got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (dp !== 4'h0) begin errors++; $display("[TB] FAIL basic_dp got %h want %h", dp, 4'h0); end
    endtask

    task automatic test_back_to_back();
        int startCount;
        startCount = fvCount;
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 6);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL repeat_frame_count got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (lastChanged !== 1'b0) begin errors++; $display("[TB] FAIL repeat_changed got %b want 0", lastChanged); end
        checks++; if (digits !== 16'h4321) begin errors++; $display("[TB] FAIL repeat_digits got %h want %h", digits, 16'h4321); end
    endtask

    task automatic test_interleave();
        int startCount;
        startCount = fvCount;
        driveDigit(4'b1110, 8'h90, 5);
        driveDigit(4'b1111, 8'hFF, 5);
        driveDigit(4'b1100, 8'hF9, 5);
        driveDigit(4'b1101, 8'h88, 5);
        driveDigit(4'b1111, 8'h90, 5);
        driveDigit(4'b1100, 8'h88, 5);
        driveDigit(4'b1011, 8'h83, 5);
        driveDigit(4'b1111, 8'hFF, 5);
        driveDigit(4'b1100, 8'h00, 5);
        @(negedge CLK);
        checks++; if (fvCount !== startCount) begin errors++; $display("[TB] FAIL interleave_no_early_frame got %0d want %0d", fvCount - startCount, 0); end
        driveDigit(4'b0111, 8'hC6, 5);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL interleave_frame_count got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (digits !== 16'hCBA9) begin errors++; $display("[TB] FAIL interleave_digits got %h want %h", digits, 16'hCBA9); end
        checks++; if (decode_err !== 1'b0) begin errors++; $display("[TB] FAIL interleave_err got %b want 0", decode_err); end
    endtask

    task automatic test_short_hold();
        int startCount;
        startCount = fvCount;
        driveDigit(4'b1110, 8'h92, 4);
        driveDigit(4'b1101, 8'h82, 4);
        driveDigit(4'b1011, 8'hF8, 3);
        driveDigit(4'b0111, 8'h80, 4);
        blankBus(3);
        checks++; if (fvCount !== startCount) begin errors++; $display("[TB] FAIL short_no_frame got %0d want %0d", fvCount - startCount, 0); end
        checks++; if (digits !== 16'hCBA9) begin errors++; $display("[TB] FAIL short_digits_held got %h want %h", digits, 16'hCBA9); end
        scan(8'h92, 8'h82, 8'hF8, 8'h80, 4);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL short_one_frame got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (digits !== 16'h8765) begin errors++; $display("[TB] FAIL short_digits got %h want %h", digits, 16'h8765); end
        checks++; if (lastChanged !== 1'b1) begin errors++; $display("[TB] FAIL short_changed got %b want 1", lastChanged); end
    endtask

    task automatic test_async_reset();
        int startCount;
        applyReset();
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
        driveDigit(4'b1110, 8'h86, 5);
        driveDigit(4'b1101, 8'hA1, 5);
        driveDigit(4'b1011, 8'hC6, 5);
        @(negedge CLK);
        checks++; if (digits !== 16'h4321) begin errors++; $display("[TB] FAIL arst_pre_digits got %h want %h", digits, 16'h4321); end
        #2;
        RST      = 1'b0;
        ctrlBits = 4'b1111;
        dispcode = 8'hFF;
        #1;
        checks++; if (digits !== 16'h0000) begin errors++; $display("[TB] FAIL arst_digits got %h want %h", digits, 16'h0000); end
        checks++; if (frame_valid !== 1'b0 || changed !== 1'b0 || dp !== 4'h0 || decode_err !== 1'b0) begin
            errors++; $display("[TB] FAIL arst_flags got fv=%b ch=%b dp=%h err=%b want 0", frame_valid, changed, dp, decode_err);
        end
        @(negedge CLK);
        RST = 1'b1;
        startCount = fvCount;
        driveDigit(4'b1110, 8'hF9, 5);
        driveDigit(4'b1101, 8'hA4, 5);
        driveDigit(4'b1011, 8'hB0, 5);
        blankBus(3);
        checks++; if (fvCount !== startCount) begin errors++; $display("[TB] FAIL arst_no_partial got %0d want %0d", fvCount - startCount, 0); end
        driveDigit(4'b0111, 8'h99, 5);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL arst_frame got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (digits !== 16'h4321) begin errors++; $display("[TB] FAIL arst_digits_after got %h want %h", digits, 16'h4321); end
    endtask

    task automatic test_dp_err();
        int startCount;
        applyReset();
        startCount = fvCount;
        driveDigit(4'b1110, 8'hF9, 5);
        driveDigit(4'b1101, 8'h00, 5);
        driveDigit(4'b1011, 8'hA4, 5);
        blankBus(2);
        checks++; if (decode_err !== 1'b0) begin errors++; $display("[TB] FAIL dperr_err_early got %b want 0", decode_err); end
        driveDigit(4'b0111, 8'hFF, 5);
        blankBus(3);
        checks++; if (fvCount !== startCount + 1) begin errors++; $display("[TB] FAIL dperr_frame got %0d want %0d", fvCount - startCount, 1); end
        checks++; if (digits !== 16'h0281) begin errors++; $display("[TB] FAIL dperr_digits got %h want %h", digits, 16'h0281); end
        checks++; if (dp !== 4'b0010) begin errors++; $display("[TB] FAIL dperr_dp got %b want %b", dp, 4'b0010); end
        checks++; if (decode_err !== 1'b1) begin errors++; $display("[TB] FAIL dperr_err_set got %b want 1", decode_err); end
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 5);
        blankBus(3);
        checks++; if (digits !== 16'h4321) begin errors++; $display("[TB] FAIL dperr_clean_digits got %h want %h", digits, 16'h4321); end
        checks++; if (dp !== 4'b0000) begin errors++; $display("[TB] FAIL dperr_clean_dp got %b want %b", dp, 4'b0000); end
        checks++; if (decode_err !== 1'b1) begin errors++; $display("[TB] FAIL dperr_sticky got %b want 1", decode_err); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        fvCount     = 0;
        lastChanged = 1'b0;
        RST         = 1'b0;
        ctrlBits    = 4'b1111;
        dispcode    = 8'hFF;

        test_reset();
        test_basic();
        test_back_to_back();
        test_interleave();
        test_short_hold();
        test_async_reset();
        test_dp_err();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
